online_adder_serial: RTL and testbench
======================================

Name: online_adder_serial

Overview:
- Digit-serial, MSD-first online adder/subtractor for radix-2 signed-digit (SD) operands; successor to the digit-parallel online adder.
- Adds one digit per channel per cycle across NCH lanes that share one handshake.
- Online delay 2, registered output, valid/ready on both sides.
- Each NDIG-digit frame produces NDIG+1 output digits; the extra digit is the overflow MSD.
- Optional per-frame subtract mode.

Parameters:
- NDIG, 8: digits per operand frame (>=2).
- NCH, 1: parallel channels (>=1).

Ports:
- clk  in  1  Clock, rising edge.
- rst_n  in  1  Asynchronous reset, active low.
- in_valid  in  1  Digit pair presented.
- in_ready  out  1  Digit pair accepted when in_valid && in_ready.
- in_x  in  2*NCH  One x digit per channel; channel c uses bits [2c+1:2c]; bit1 = plus, bit0 = minus.
- in_y  in  2*NCH  One y digit per channel, same encoding as in_x.
- in_sub  in  1  Subtract mode; sampled with digit 0 only.
- in_last  in  1  Marks the final digit of a frame.
- out_valid  out  1  Output digits valid.
- out_ready  in  1  Output consumed when out_valid && out_ready.
- out_z  out  2*NCH  One output SD digit per channel.
- out_last  out  1  Marks output digit NDIG (the final digit).
- err_len  out  1  One-cycle pulse on a frame length mismatch.

Behaviour:
- Digit encoding: {p,n} has value p-n. Input 11 is treated as 0. Output is only ever 10 (+1), 01 (-1) or 00 (0).
- Subtract mode: when the frame's sub bit is 1, the y digit is negated by swapping p and n.
- Per channel, for each digit j: s_j = x_j + y_j, range [-2,2], 3-bit signed.
- Transfer t_j and interim w_j are chosen using the less-significant sum s_{j+1}:
  - s=2: t=1, w=0.
  - s=-2: t=-1, w=0.
  - s=0: t=0, w=0.
  - s=1: t=1, w=-1 if s_{j+1}>=0; else t=0, w=1.
  - s=-1: t=0, w=-1 if s_{j+1}>=0; else t=-1, w=1.
- Output digits:
  - o_0 = t_0.
  - o_k = w_{k-1} + t_k for 1<=k<=NDIG-1.
  - o_NDIG = w_{NDIG-1}.
  - s_NDIG is taken as 0.
- Result: value(o) with weights 2^0..2^-NDIG equals value(x) + value(y) with weights 2^-1..2^-NDIG (x - y in subtract mode). |o_k| <= 1 always.
- Output register: slot_free = !out_valid || out_ready. The output register loads only when slot_free.
- Input handshake: in_ready = slot_free && state in {IDLE, RUN}.
- State IDLE:
  - Accepting digit 0 latches s_0 and the sub bit and clears the digit counter.
  - No output is produced; go to RUN.
- State RUN:
  - Accepting digit j>=1 computes t_{j-1}, w_{j-1} and loads out_z = o_{j-1}, out_valid=1.
  - s_j and w_{j-1} are stored; the counter increments.
- Frame end:
  - The frame ends when the accepted digit has in_last=1 or counter = NDIG-1, whichever occurs first. Then go to FLUSH1.
  - err_len pulses for 1 cycle if in_last and counter==NDIG-1 disagree.
  - A frame always completes with the digits received; missing digits are not padded.
- FLUSH1: when slot_free, emit o_{NDIG-1} (using s_NDIG=0); go to FLUSH2.
- FLUSH2: when slot_free, emit o_NDIG with out_last=1; go to IDLE.
- While in FLUSH1/FLUSH2, in_ready=0.
- in_last on digit 0 is an error: err_len pulses and the frame proceeds as a 1-digit frame. FLUSH1 emits o_0, then FLUSH2 emits o_1.
- Output consumed without a new load: out_valid clears.
- Latency with continuous traffic: digit k accepted in cycle k gives o_k visible in cycle k+2. A frame occupies NDIG+2 cycles including the flush.
- Back-to-back frames: digit 0 of the next frame is accepted in the cycle after FLUSH2 is left.
- in_valid low mid-frame: the state is held and nothing is emitted.
- out_ready low: out_z, out_valid and out_last are held stable, and in_ready=0.
- Reset (asynchronous, any time, including mid-frame):
  - State returns to IDLE; the partial frame is discarded.
  - out_valid, out_z, out_last and err_len are all 0.
  - in_ready = 1 after release.

Test Plan:
- NDIG=4, x=[1,0,1,1], y=[1,1,0,-1], continuous -> out_z 10,10,00,01,00 in cycles 2..6; out_last in cycle 6 (1.375).
- in_sub=1, x=[1,0,0,0], y=[0,0,0,1] -> 10,01,00,00,01 (0.4375).
- Negative lookahead: x=[1,-1,0,0], y=0 -> 00,10,01,00,00 (0.25).
- Repeat the first scenario with out_ready toggled 1,0,0,1,... and in_valid gaps -> identical digit sequence, no drops or duplicates, outputs stable while stalled.
- in_last on the third digit with NDIG=4 -> err_len pulse; 4 output digits, the last with out_last.
- Reset asserted after digit 2 -> outputs 0 immediately; the next clean frame is correct.
- NCH=2: lanes carry the first and second scenarios' operands with in_sub=0 -> each lane matches its single-lane reference.

Source files
------------

// File: rtl/online_adder_serial.sv
// Digit-serial MSD-first radix-2 signed-digit online adder/subtractor, online delay 2.
// NCH lanes share one valid/ready handshake; each NDIG-digit frame yields NDIG+1 digits.
module online_adder_serial #(
  parameter int NDIG = 8,
  parameter int NCH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*NCH-1:0] in_x,
  input  logic [2*NCH-1:0] in_y,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*NCH-1:0] out_z,
  output logic             out_last,
  output logic             err_len
);
  // state  | meaning
  // IDLE   | waiting for digit 0 of a frame
  // RUN    | accepting digits 1.., emitting o_{j-1}
  // FLUSH1 | emitting o_{m-1} with zero lookahead
  // FLUSH2 | emitting the final transfer-free digit o_m
  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  localparam int CW = $clog2(NDIG);
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d, idx;
  logic             sub_q, sub_d, sub_eff;
  logic [3*NCH-1:0] s_q, s_d, s_new;
  logic [2*NCH-1:0] w_q, w_d, w_new;
  logic [2*NCH-1:0] z_run, z_fl2, z_d;
  logic [1:0]       xd, yd;
  logic [2:0]       sn, o_lane;
  logic [3:0]       tw;
  logic             look_neg, slot_free, acc, load, last_d, err_d, cnt_end;

  function automatic logic signed [2:0] dig_val(input logic [1:0] d);
    return $signed({2'b00, d[1]}) - $signed({2'b00, d[0]});
  endfunction

  // {t, w} as two 2-bit two's complement fields; look_neg means s_{j+1} < 0
  function automatic logic [3:0] sel_tw(input logic [2:0] s, input logic look_neg_i);
    logic [3:0] r;
    r = 4'b0000;
    case (s)
      3'b010:  r = {2'b01, 2'b00};
      3'b110:  r = {2'b11, 2'b00};
      3'b001:  r = look_neg_i ? {2'b00, 2'b01} : {2'b01, 2'b11};
      3'b111:  r = look_neg_i ? {2'b11, 2'b01} : {2'b00, 2'b11};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] enc(input logic [2:0] o);
    case (o)
      3'b001:  return 2'b10;
      3'b111:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free && (state == IDLE || state == RUN);
    acc       = in_valid && in_ready;
    sub_eff   = (state == IDLE) ? in_sub : sub_q;
    idx       = cnt + CW'(1);
    cnt_end   = (idx == LAST_IDX);
    s_new     = '0;
    w_new     = '0;
    z_run     = '0;
    z_fl2     = '0;
    xd        = '0;
    yd        = '0;
    sn        = '0;
    tw        = '0;
    o_lane    = '0;
    look_neg  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      xd = in_x[2*c +: 2];
      yd = sub_eff ? {in_y[2*c], in_y[2*c+1]} : in_y[2*c +: 2];
      sn = dig_val(xd) + dig_val(yd);
      s_new[3*c +: 3] = sn;
      // outside RUN the lookahead digit is beyond the frame and counts as zero
      look_neg = (state == RUN) && sn[2];
      tw = sel_tw(s_q[3*c +: 3], look_neg);
      o_lane = {w_q[2*c+1], w_q[2*c +: 2]} + {tw[3], tw[3:2]};
      w_new[2*c +: 2] = tw[1:0];
      z_run[2*c +: 2] = enc(o_lane);
      z_fl2[2*c +: 2] = enc({w_q[2*c+1], w_q[2*c +: 2]});
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sub_d   = sub_q;
    s_d     = s_q;
    w_d     = w_q;
    z_d     = z_run;
    load    = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: if (acc) begin
        s_d     = s_new;
        w_d     = '0;
        sub_d   = in_sub;
        cnt_d   = '0;
        err_d   = in_last;
        state_d = in_last ? FLUSH1 : RUN;
      end
      RUN: if (acc) begin
        load  = 1'b1;
        s_d   = s_new;
        w_d   = w_new;
        cnt_d = idx;
        if (in_last || cnt_end) begin
          err_d   = in_last ^ cnt_end;
          state_d = FLUSH1;
        end
      end
      FLUSH1: if (slot_free) begin
        load    = 1'b1;
        w_d     = w_new;
        state_d = FLUSH2;
      end
      FLUSH2: if (slot_free) begin
        load    = 1'b1;
        z_d     = z_fl2;
        last_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sub_q     <= 1'b0;
      s_q       <= '0;
      w_q       <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      w_q     <= w_d;
      err_len <= err_d;
      if (load) begin
        out_valid <= 1'b1;
        out_z     <= z_d;
        out_last  <= last_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_online_adder_serial.sv
// Bench for online_adder_serial: directed and random frames scored against an
// arithmetic reference (digit sequence plus numeric value of every frame).
module tb_online_adder_serial;
  localparam int NDIG = 4;
  localparam int NCH  = 2;
  localparam int W    = 2 * NCH;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_sub, in_last;
  logic         out_valid, out_ready, out_last, err_len;
  logic [W-1:0] in_x, in_y, out_z;

  online_adder_serial #(.NDIG(NDIG), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_last(out_last), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] z; logic last; } exp_t;
  exp_t         exp_q[$];
  exp_t         e_mon;
  int           exp_val_q[NCH][$];
  int           xa[NCH][NDIG];
  int           ya[NCH][NDIG];
  int           n_checks = 0, n_pass = 0;
  int           cyc = 0, in_frame = 0, out_frame = 0, exp_err = 0, err_seen = 0;
  int           acc0_cyc[8], first_cyc[8], last_cyc[8];
  int           lane_acc[NCH];
  bit           frame_open = 0, hold_pending = 0, rdy_mode = 0;
  logic [W-1:0] hold_z;
  logic         hold_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] enc_dig(input int v, input bit alt_zero);
    if (v > 0) return 2'b10;
    if (v < 0) return 2'b01;
    return alt_zero ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] enc_out(input int v);
    if (v == 1)  return 2'b10;
    if (v == -1) return 2'b01;
    if (v == 0)  return 2'b00;
    return 2'b11;
  endfunction

  function automatic int dval(input logic [1:0] d);
    return int'(d[1]) - int'(d[0]);
  endfunction

  // Reference: digit sums, transfer/interim selection, expected digits and value.
  function automatic void model(input bit sub, input int m);
    logic [W-1:0] zv[NDIG+1];
    int s[NDIG+1];
    int t[NDIG];
    int w[NDIG];
    int o, val;
    for (int k = 0; k <= NDIG; k++) zv[k] = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j <= NDIG; j++)
        s[j] = (j < m) ? xa[c][j] + (sub ? -ya[c][j] : ya[c][j]) : 0;
      val = 0;
      for (int j = 0; j < m; j++) val += s[j] * (1 << (m - 1 - j));
      exp_val_q[c].push_back(val);
      for (int j = 0; j < m; j++) begin
        t[j] = 0; w[j] = 0;
        if (s[j] == 2)       t[j] = 1;
        else if (s[j] == -2) t[j] = -1;
        else if (s[j] == 1) begin
          if (s[j+1] >= 0) begin t[j] = 1; w[j] = -1; end
          else             begin t[j] = 0; w[j] = 1;  end
        end else if (s[j] == -1) begin
          if (s[j+1] >= 0) begin t[j] = 0;  w[j] = -1; end
          else             begin t[j] = -1; w[j] = 1;  end
        end
      end
      for (int k = 0; k <= m; k++) begin
        o = ((k < m) ? t[k] : 0) + ((k > 0) ? w[k-1] : 0);
        zv[k][2*c +: 2] = enc_out(o);
      end
    end
    for (int k = 0; k <= m; k++) exp_q.push_back('{z: zv[k], last: (k == m)});
  endfunction

  task automatic set_ops(input int lane, input int x0, input int x1, input int x2, input int x3,
                         input int y0, input int y1, input int y2, input int y3);
    xa[lane][0] = x0; xa[lane][1] = x1; xa[lane][2] = x2; xa[lane][3] = x3;
    ya[lane][0] = y0; ya[lane][1] = y1; ya[lane][2] = y2; ya[lane][3] = y3;
  endtask

  task automatic rand_ops(input int lane);
    for (int j = 0; j < NDIG; j++) begin
      xa[lane][j] = int'($urandom_range(0, 2)) - 1;
      ya[lane][j] = int'($urandom_range(0, 2)) - 1;
    end
  endtask

  task automatic drive_digit(input int j, input bit sub, input bit last);
    in_valid = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      in_x[2*c +: 2] = enc_dig(xa[c][j], 1'($urandom_range(0, 1)));
      in_y[2*c +: 2] = enc_dig(ya[c][j], 1'($urandom_range(0, 1)));
    end
    in_sub  = (j == 0) ? sub : 1'($urandom_range(0, 1));
    in_last = last;
  endtask

  task automatic send_frame(input bit sub, input int m, input bit last_fin, input int gap_pct);
    int tmo;
    model(sub, m);
    if (m < NDIG || !last_fin) exp_err++;
    for (int j = 0; j < m; j++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_x     = W'($urandom);
        in_y     = W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      drive_digit(j, sub, (j == m - 1) && last_fin);
      tmo = 0;
      forever begin
        @(negedge clk);
        if (in_ready === 1'b1) break;
        tmo++;
        if (tmo > 200) begin chk("accept_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      if (j == 0 && in_frame < 8) acc0_cyc[in_frame] = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_frame++;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while (exp_q.size() > 0 && tmo < 1000) begin @(posedge clk); tmo++; end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("err_count", err_seen, exp_err);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (err_len === 1'b1) err_seen++;
      if (hold_pending) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_z", out_z, hold_z);
        chk("hold_last", out_last, hold_last);
        hold_pending = 0;
      end
      if (out_valid && !out_ready) begin
        hold_pending = 1;
        hold_z       = out_z;
        hold_last    = out_last;
        chk("stall_in_ready", in_ready, 0);
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("out_z", out_z, e_mon.z);
          chk("out_last", out_last, e_mon.last);
        end
        if (!frame_open) begin
          frame_open = 1;
          if (out_frame < 8) first_cyc[out_frame] = cyc;
        end
        for (int c = 0; c < NCH; c++) lane_acc[c] = lane_acc[c] * 2 + dval(out_z[2*c +: 2]);
        if (out_last) begin
          for (int c = 0; c < NCH; c++) begin
            if (exp_val_q[c].size() > 0) chk("frame_value", lane_acc[c], exp_val_q[c].pop_front());
            else chk("value_q_empty", 1, 0);
            lane_acc[c] = 0;
          end
          if (out_frame < 8) last_cyc[out_frame] = cyc;
          out_frame++;
          frame_open = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    for (int c = 0; c < NCH; c++) lane_acc[c] = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // continuous directed frames, back to back
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1); rand_ops(1); send_frame(0, NDIG, 1, 0);
    set_ops(0, 1, 0, 0, 0, 0, 0, 0, 1);  rand_ops(1); send_frame(1, NDIG, 1, 0);
    set_ops(0, 1, -1, 0, 0, 0, 0, 0, 0); rand_ops(1); send_frame(0, NDIG, 1, 0);
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1);
    set_ops(1, 1, 0, 0, 0, 0, 0, 0, 1);  send_frame(0, NDIG, 1, 0);
    drain();
    chk("lat_first_digit", first_cyc[0] - acc0_cyc[0], 1);
    chk("lat_last_digit", last_cyc[0] - acc0_cyc[0], 5);
    chk("b2b_frame_period", acc0_cyc[1] - acc0_cyc[0], NDIG + 2);
    chk("b2b_frame_period2", acc0_cyc[3] - acc0_cyc[2], NDIG + 2);

    // frame length errors: early last, last on digit 0, missing last
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1); rand_ops(1); send_frame(0, 3, 1, 0);
    rand_ops(0); rand_ops(1); send_frame(1, 1, 1, 0);
    rand_ops(0); rand_ops(1); send_frame(0, NDIG, 0, 0);
    drain();

    // back-pressure and input gaps
    rdy_mode = 1;
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1); rand_ops(1); send_frame(0, NDIG, 1, 30);
    for (int i = 0; i < 150; i++) begin
      rand_ops(0); rand_ops(1);
      r = int'($urandom_range(0, 9));
      if (r < 7)       send_frame(1'($urandom_range(0, 1)), NDIG, 1, 20);
      else if (r == 7) send_frame(1'($urandom_range(0, 1)), NDIG, 0, 20);
      else             send_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, NDIG - 1)), 1, 20);
    end
    rdy_mode = 0;
    drain();

    // reset in the middle of a frame
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1); rand_ops(1);
    model(0, NDIG);
    for (int j = 0; j < 3; j++) begin
      drive_digit(j, 1'b0, 1'b0);
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_z", out_z, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_err_len", err_len, 0);
    in_valid = 1'b0;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin exp_val_q[c].delete(); lane_acc[c] = 0; end
    frame_open = 0; hold_pending = 0; exp_err = 0; err_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    set_ops(0, 1, 0, 1, 1, 1, 1, 0, -1); rand_ops(1); send_frame(0, NDIG, 1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
